// File: rtl/sine_lut_arbiter.sv
// Round-robin arbiter sharing one registered sine table between N requesters.
// Each lookup carries its requester ID down a shift register to steer the result.
module sine_lut_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int LUT_LAT = 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_addr,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic [DW-1:0]   resp_data,
    output logic            lut_en,
    output logic [DW-1:0]   lut_addr,
    input  logic [DW-1:0]   lut_data,
    output logic            busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  gnt_idx;
    logic           gnt_any;
    logic [DW-1:0]  gnt_addr;
    logic [LUT_LAT:0] vld;
    logic [PW-1:0]  id_q [LUT_LAT+1];
    int             j;

    // First valid index at or after ptr, wrapping around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N)
                j = j - N;
            if (!gnt_any && req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any)
            req_ready = N'(1) << gnt_idx;
    end

    assign gnt_addr = req_addr[gnt_idx*DW +: DW];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr      <= '0;
            lut_addr <= '0;
        end else if (gnt_any) begin
            lut_addr <= gnt_addr;
            if (gnt_idx == PW'(N - 1))
                ptr <= '0;
            else
                ptr <= gnt_idx + 1'b1;
        end
    end

    // vld[0] marks the table-issue cycle; vld[LUT_LAT] aligns with lut_data.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld <= '0;
            for (int k = 0; k <= LUT_LAT; k++)
                id_q[k] <= '0;
        end else begin
            vld[0] <= gnt_any;
            if (gnt_any)
                id_q[0] <= gnt_idx;
            for (int k = 1; k <= LUT_LAT; k++) begin
                vld[k]  <= vld[k-1];
                id_q[k] <= id_q[k-1];
            end
        end
    end

    assign lut_en = vld[0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            if (vld[LUT_LAT]) begin
                resp_valid <= N'(1) << id_q[LUT_LAT];
                resp_data  <= lut_data;
            end
        end
    end

    assign busy = (|vld) | (|resp_valid);

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Directed bench for sine_lut_arbiter with LUT_LAT=1 and LUT_LAT=3 instances.
// Table contents are a simple known function modelled here.
module tb_sine_lut_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic [3:0]  a_valid, a_ready, a_resp;
    logic [31:0] a_addr;
    logic [7:0]  a_data, a_lut_addr, a_lut_data, a_p0;
    logic        a_lut_en, a_busy;
    logic [3:0]  b_valid, b_ready, b_resp;
    logic [31:0] b_addr;
    logic [7:0]  b_data, b_lut_addr, b_lut_data, b_p0, b_p1, b_p2;
    logic        b_lut_en, b_busy;
    int          checks = 0;
    int          errors = 0;
    int          w;

    always #5 clk = ~clk;

    sine_lut_arbiter #(.N(4), .DW(8), .LUT_LAT(1)) u_a (
        .clk(clk), .nreset(nreset),
        .req_valid(a_valid), .req_addr(a_addr), .req_ready(a_ready),
        .resp_valid(a_resp), .resp_data(a_data),
        .lut_en(a_lut_en), .lut_addr(a_lut_addr), .lut_data(a_lut_data),
        .busy(a_busy)
    );

    sine_lut_arbiter #(.N(4), .DW(8), .LUT_LAT(3)) u_b (
        .clk(clk), .nreset(nreset),
        .req_valid(b_valid), .req_addr(b_addr), .req_ready(b_ready),
        .resp_valid(b_resp), .resp_data(b_data),
        .lut_en(b_lut_en), .lut_addr(b_lut_addr), .lut_data(b_lut_data),
        .busy(b_busy)
    );

    function automatic logic [7:0] tbl(input logic [7:0] a);
        logic [7:0] m;
        m = a * 8'd3;
        return m ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        a_p0 <= tbl(a_lut_addr);
        b_p0 <= tbl(b_lut_addr);
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign a_lut_data = a_p0;
    assign b_lut_data = b_p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        nreset  = 1'b0;
        a_valid = '0;
        a_addr  = '0;
        b_valid = '0;
        b_addr  = '0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        do_reset();
        #1;
        chk("rst lut_en", a_lut_en, 0);
        chk("rst lut_addr", a_lut_addr, 0);
        chk("rst resp", a_resp, 0);
        chk("rst data", a_data, 0);
        chk("rst busy", a_busy, 0);
        chk("rst ready", a_ready, 0);

        // single lookup from requester 0
        a_valid = 4'b0001;
        a_addr  = 32'h0000_0040;
        #1 chk("t1 ready", a_ready, 4'b0001);
        @(negedge clk);
        a_valid = '0;
        chk("t1 lut_en", a_lut_en, 1);
        chk("t1 lut_addr", a_lut_addr, 8'h40);
        chk("t1 busy c1", a_busy, 1);
        chk("t1 resp c1", a_resp, 0);
        @(negedge clk);
        chk("t1 busy c2", a_busy, 1);
        chk("t1 resp c2", a_resp, 0);
        @(negedge clk);
        chk("t1 resp c3", a_resp, 4'b0001);
        chk("t1 data c3", a_data, tbl(8'h40));
        chk("t1 busy c3", a_busy, 1);
        @(negedge clk);
        chk("t1 busy c4", a_busy, 0);
        chk("t1 resp c4", a_resp, 0);

        // all four requesting continuously
        do_reset();
        a_valid = 4'b1111;
        a_addr  = 32'h4030_2010;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t2 ready", a_ready, 32'(4'b0001 << (c % 4)));
            if (c >= 3) begin
                chk("t2 resp", a_resp, 32'(4'b0001 << ((c - 3) % 4)));
                chk("t2 data", a_data, tbl(8'(8'h10 * ((c - 3) % 4 + 1))));
            end
            @(negedge clk);
        end
        a_valid = '0;
        repeat (5) @(negedge clk);
        chk("t2 idle busy", a_busy, 0);

        // requesters 1 and 3 with ptr starting at 2
        do_reset();
        a_valid = 4'b0010;
        a_addr  = 32'h3300_2100;
        #1 chk("t3 setup", a_ready, 4'b0010);
        @(negedge clk);
        a_valid = 4'b1010;
        #1 chk("t3 g3", a_ready, 4'b1000);
        @(negedge clk);
        #1 chk("t3 g1", a_ready, 4'b0010);
        chk("t3 lut_addr", a_lut_addr, 8'h33);
        @(negedge clk);
        #1 chk("t3 g3b", a_ready, 4'b1000);
        chk("t3 lut_addr b", a_lut_addr, 8'h21);
        @(negedge clk);
        a_valid = '0;
        repeat (5) @(negedge clk);

        // requester 2 joins three busy requesters
        do_reset();
        a_valid = 4'b1011;
        a_addr  = 32'h4477_2211;
        repeat (3) @(negedge clk);
        a_valid = 4'b1111;
        w = 0;
        while (w < 8) begin
            #1;
            if (a_ready[2])
                break;
            @(negedge clk);
            w++;
        end
        chk("t4 wait", w, 2);
        @(negedge clk);
        a_valid = '0;
        chk("t4 lut_addr", a_lut_addr, 8'h77);
        repeat (5) @(negedge clk);

        // reset with two lookups in flight
        do_reset();
        a_valid = 4'b0001;
        a_addr  = 32'h0000_2211;
        @(negedge clk);
        a_valid = 4'b0010;
        @(negedge clk);
        a_valid = '0;
        nreset  = 1'b0;
        #1;
        chk("t5 resp c2", a_resp, 0);
        chk("t5 busy c2", a_busy, 0);
        @(negedge clk);
        chk("t5 resp c3", a_resp, 0);
        @(negedge clk);
        nreset = 1'b1;
        chk("t5 resp c4", a_resp, 0);
        for (int c = 5; c < 8; c++) begin
            @(negedge clk);
            chk("t5 resp", a_resp, 0);
            chk("t5 busy", a_busy, 0);
        end
        a_valid = 4'b0110;
        #1 chk("t5 next grant", a_ready, 4'b0010);
        @(negedge clk);
        a_valid = '0;
        repeat (4) @(negedge clk);

        // LUT_LAT=3 instance
        do_reset();
        b_valid = 4'b0010;
        b_addr  = 32'h0000_C000;
        #1 chk("t6 ready", b_ready, 4'b0010);
        @(negedge clk);
        b_valid = '0;
        chk("t6 lut_en", b_lut_en, 1);
        chk("t6 lut_addr", b_lut_addr, 8'hC0);
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            chk("t6 resp early", b_resp, 0);
            chk("t6 busy", b_busy, 1);
        end
        @(negedge clk);
        chk("t6 resp c5", b_resp, 4'b0010);
        chk("t6 data c5", b_data, tbl(8'hC0));
        @(negedge clk);
        chk("t6 resp c6", b_resp, 0);
        chk("t6 busy c6", b_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
